// File: rtl/oh_arbmux2_if.sv
// oh_arbmux2_if: two-producer / one-consumer valid-ready bundle.
// The arbiter takes the slave view; traffic generators take master.
interface oh_arbmux2_if #(
    parameter int DW = 32
);
    logic          in0_valid;
    logic [DW-1:0] in0_data;
    logic          in0_ready;
    logic          in1_valid;
    logic [DW-1:0] in1_data;
    logic          in1_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_src;
    logic          out_ready;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/oh_arbmux2.sv
// oh_arbmux2: two-input round-robin arbitrated mux with registered output.
// Grants gate the buses through an inverting and-or, re-inverted at the flop.
module oh_arbmux2 #(
    parameter int DW = 32
) (
    input  logic        clk,
    input  logic        nreset,
    oh_arbmux2_if.slave bus
);

    logic          g0;
    logic          g1;
    logic          load;
    logic          xfer;
    logic [DW-1:0] mux_n;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic          out_src_q,   out_src_d;
    logic          last_q,      last_d;

    // Round-robin grant: on contention the input that did not win last goes.
    always_comb begin
        g0    = bus.in0_valid & (~bus.in1_valid | last_q);
        g1    = bus.in1_valid & (~bus.in0_valid | ~last_q);
        load  = ~out_valid_q | bus.out_ready;
        xfer  = load & (g0 | g1);
        mux_n = ~((bus.in0_data & {DW{g0}}) | (bus.in1_data & {DW{g1}}));
    end

    // Next state: load on a free/draining register, priority moves only on transfer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = g0 | g1;
        end
        if (xfer) begin
            out_data_d = ~mux_n;
            out_src_d  = g1;
            last_d     = g1;
        end
    end

    // State register; reset discards any held beat and favours input 0.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
        end
    end

    assign bus.in0_ready = load & g0;
    assign bus.in1_ready = load & g1;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule
